// File: rtl/decrypt_sequencer.sv
// decrypt_sequencer
//   Walks every pixel of the R/G/B image planes. Each channel byte is read,
//   XORed with one keystream byte from the RNG and written back in place.
//   The same schedule encrypts, because XOR with the key is its own inverse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   start      start request, honoured only in IDLE or DONE
//   seed_load  one-cycle pulse: RNG reloads its seed
//   key_req    keystream request; byte consumed when key_req && key_valid
//   key_valid  keystream byte available
//   key_data   keystream byte
//   rd_en      memory read strobe (read data returns one cycle later)
//   rd_addr    pixel address, shared by read and write
//   ch         plane select 0=R 1=G 2=B
//   rd_data    memory read data
//   wr_en      write strobe
//   wr_data    decrypted byte
//   busy       high from LOAD through WR
//   done       frame complete, held until the next accepted start
module decrypt_sequencer #(
  parameter int NUM_PIXELS = 4096,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              seed_load,
  output logic              key_req,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        ch,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  // Terminal address held at ADDR_W bits so NUM_PIXELS = 2^ADDR_W never
  // needs a wider counter: the counter stops at the last pixel, never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    KEY  = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        ch_reg, ch_next;
  logic [DATA_W-1:0] pix_reg, pix_next;
  logic [DATA_W-1:0] key_reg, key_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      ch_reg    <= '0;
      pix_reg   <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      ch_reg    <= ch_next;
      pix_reg   <= pix_next;
      key_reg   <= key_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    ch_next    = ch_reg;
    pix_next   = pix_reg;
    key_next   = key_reg;
    seed_load  = 1'b0;
    key_req    = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        seed_load  = 1'b1;
        addr_next  = '0;
        ch_next    = '0;
        state_next = RD;
      end
      RD: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        state_next = CAP;
      end
      CAP: begin
        busy       = 1'b1;
        pix_next   = rd_data;
        state_next = KEY;
      end
      KEY: begin
        // Leaving KEY right after the handshake drops key_req next cycle,
        // so exactly one byte is taken per visit.
        busy    = 1'b1;
        key_req = 1'b1;
        if (key_valid) begin
          key_next   = key_data;
          state_next = WR;
        end
      end
      WR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_data = pix_reg ^ key_reg;
        if (ch_reg < 2'd2) begin
          ch_next    = ch_reg + 2'd1;
          state_next = RD;
        end else if (addr_reg < LAST_ADDR) begin
          ch_next    = 2'd0;
          addr_next  = addr_reg + 1'b1;
          state_next = RD;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_addr = addr_reg;
  assign ch      = ch_reg;

endmodule
